// File: rtl/maxnet_pkg.sv
// Shared definitions for the Maxnet float32 datapath: field slices, the
// canonical +0 constant and the accumulator state encoding.
package maxnet_pkg;

  localparam logic [31:0] FP_ZERO  = 32'h0000_0000;
  localparam int          SIGN_BIT = 31;
  localparam int          EXP_MSB  = 30;
  localparam int          EXP_LSB  = 23;
  localparam int          MAN_MSB  = 22;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } acc_state_t;

endpackage

// File: rtl/fp_accumulator_adder.sv
// Combinational float32 adder: align, add/subtract, renormalise, truncate.
// Zero, denormal, Inf and NaN inputs are not special-cased.
module Adder
  import maxnet_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] y
);

  logic        big_a;
  logic [31:0] x;
  logic [31:0] z;
  logic [7:0]  ex;
  logic [7:0]  ez;
  logic [7:0]  sh;
  logic [23:0] mx;
  logic [23:0] mz;
  logic [23:0] mz_al;
  logic [24:0] sum;
  logic [23:0] dif;
  logic [4:0]  lz;
  logic [7:0]  exp_r;
  logic [22:0] frac_r;

  always_comb begin
    // Order operands by magnitude so the subtraction path never goes negative.
    big_a  = a[EXP_MSB:0] >= b[EXP_MSB:0];
    x      = big_a ? a : b;
    z      = big_a ? b : a;
    ex     = x[EXP_MSB:EXP_LSB];
    ez     = z[EXP_MSB:EXP_LSB];
    mx     = {1'b1, x[MAN_MSB:0]};
    mz     = {1'b1, z[MAN_MSB:0]};
    sh     = ex - ez;
    mz_al  = (sh > 8'd23) ? 24'd0 : (mz >> sh);
    sum    = {1'b0, mx} + {1'b0, mz_al};
    dif    = mx - mz_al;
    lz     = 5'd0;
    for (int i = 0; i < 24; i++) begin
      if (dif[i]) lz = 5'(23 - i);
    end
    if (x[SIGN_BIT] == z[SIGN_BIT]) begin
      if (sum[24]) begin
        exp_r  = ex + 8'd1;
        frac_r = sum[23:1];
      end else begin
        exp_r  = ex;
        frac_r = sum[22:0];
      end
    end else begin
      exp_r  = ex - {3'b000, lz};
      frac_r = 23'(dif << lz);
    end
    y = {x[SIGN_BIT], exp_r, frac_r};
  end

endmodule

// File: rtl/fp_accumulator.sv
// Sequential float32 reduction: folds COUNT streamed operands into a running
// sum and presents the (optionally ReLU-clamped) total on a held handshake.
module fp_accumulator
  import maxnet_pkg::*;
#(
  parameter int N     = 32,
  parameter int COUNT = 4,
  parameter bit RELU  = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         in_valid,
  input  logic [N-1:0]                 in_data,
  output logic                         in_ready,
  output logic                         out_valid,
  output logic [N-1:0]                 out_data,
  input  logic                         out_ready,
  output logic                         busy,
  output acc_state_t                   dbg_state,
  output logic [$clog2(COUNT+1)-1:0]   dbg_cnt
);

  localparam int CW = $clog2(COUNT + 1);

  // Handshakes: a beat transfers on a rising edge where valid && ready.
  // in_ready depends on state only; out_valid/out_data hold until accepted.

  acc_state_t    state_q, state_d;
  logic [N-1:0]  acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [N-1:0]  sum;
  logic [N-1:0]  fold;
  logic [CW-1:0] cnt_inc;
  logic          accept;
  logic          op_zero;
  logic          acc_zero;
  logic          cancel;

  Adder #(.N(N)) u_adder (
    .a (acc_q),
    .b (in_data),
    .y (sum)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      acc_q   <= FP_ZERO;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  // Exact cancellation must bypass the adder: it cannot normalise a zero mantissa.
  always_comb begin
    accept   = in_valid && in_ready;
    op_zero  = in_data[EXP_MSB:EXP_LSB] == 8'd0;
    acc_zero = acc_q[EXP_MSB:EXP_LSB] == 8'd0;
    cancel   = (in_data[EXP_MSB:0] == acc_q[EXP_MSB:0]) &&
               (in_data[SIGN_BIT] != acc_q[SIGN_BIT]);
    cnt_inc  = cnt_q + CW'(1);
    if (op_zero)       fold = acc_q;
    else if (acc_zero) fold = in_data;
    else if (cancel)   fold = FP_ZERO;
    else               fold = sum;
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_ACCUM;
          acc_d   = FP_ZERO;
          cnt_d   = '0;
        end
      end
      ST_ACCUM: begin
        if (accept) begin
          acc_d = fold;
          cnt_d = cnt_inc;
          if (cnt_inc == CW'(COUNT)) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_valid && out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == ST_ACCUM);
    out_valid = (state_q == ST_DONE);
    busy      = (state_q == ST_ACCUM) || (state_q == ST_DONE);
    out_data  = (RELU && acc_q[SIGN_BIT]) ? FP_ZERO : acc_q;
    dbg_state = state_q;
    dbg_cnt   = cnt_q;
  end

endmodule
